// File: rtl/membus_avl_master_if.sv
// Memory-bus requester and Avalon-MM signals bundled for membus_avl_master.
//   Requester side : i_rq_cyc, i_rd_rq, i_wr_rq, i_ma, i_wr_rs, i_mb_write (in)
//                    o_addr_ack, o_rd_rs, o_mb_read, o_wr_done (out)
//   Avalon side    : o_address, o_read, o_write, o_writedata (out)
//                    i_readdata, i_waitrequest (in)
// Directions named from the bridge's point of view; master modport = bridge.
interface membus_avl_master_if;
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 36;

    logic          i_rq_cyc;
    logic          i_rd_rq;
    logic          i_wr_rq;
    logic [AW-1:0] i_ma;
    logic          i_wr_rs;
    logic [DW-1:0] i_mb_write;
    logic          o_addr_ack;
    logic          o_rd_rs;
    logic [DW-1:0] o_mb_read;
    logic          o_wr_done;
    logic [AW-1:0] o_address;
    logic          o_read;
    logic          o_write;
    logic [DW-1:0] o_writedata;
    logic [DW-1:0] i_readdata;
    logic          i_waitrequest;

    modport master (
        input  i_rq_cyc, i_rd_rq, i_wr_rq, i_ma, i_wr_rs, i_mb_write,
        input  i_readdata, i_waitrequest,
        output o_addr_ack, o_rd_rs, o_mb_read, o_wr_done,
        output o_address, o_read, o_write, o_writedata
    );

    modport slave (
        output i_rq_cyc, i_rd_rq, i_wr_rq, i_ma, i_wr_rs, i_mb_write,
        output i_readdata, i_waitrequest,
        input  o_addr_ack, o_rd_rs, o_mb_read, o_wr_done,
        input  o_address, o_read, o_write, o_writedata
    );
endinterface

// File: rtl/membus_avl_master.sv
// Bridges one PDP-6 style memory-bus requester onto an Avalon-MM master port.
// Supports read, write and read-pause-write cycles; addresses >= MEM_WORDS are
// never acknowledged so the requester times out (nonexistent memory).
//   i_clk, i_reset_n : clock and asynchronous active-low reset
//   bus (master)     : requester handshake plus Avalon master signals
// Every output is registered.
module membus_avl_master #(
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    membus_avl_master_if.master  bus
);
    localparam int unsigned AW = 18;
    localparam int unsigned DW = 36;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WWAIT = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic          wr_flag_q, wr_flag_d;
    logic          addr_ack_q, addr_ack_d;
    logic          rd_rs_q, rd_rs_d;
    logic          wr_done_q, wr_done_d;
    logic          read_q, read_d;
    logic          write_q, write_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] mb_read_q, mb_read_d;
    logic [DW-1:0] writedata_q, writedata_d;
    logic          req_ok_c;

    // Request is acceptable only for a present word; full 18-bit compare.
    assign req_ok_c = bus.i_rq_cyc & (bus.i_rd_rq | bus.i_wr_rq)
                    & (32'(bus.i_ma) < MEM_WORDS);

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= S_IDLE;
            wr_flag_q   <= 1'b0;
            addr_ack_q  <= 1'b0;
            rd_rs_q     <= 1'b0;
            wr_done_q   <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            mb_read_q   <= '0;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_flag_q   <= wr_flag_d;
            addr_ack_q  <= addr_ack_d;
            rd_rs_q     <= rd_rs_d;
            wr_done_q   <= wr_done_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            mb_read_q   <= mb_read_d;
            writedata_q <= writedata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wr_flag_d   = wr_flag_q;
        addr_ack_d  = 1'b0;
        rd_rs_d     = 1'b0;
        wr_done_d   = 1'b0;
        read_d      = read_q;
        write_d     = write_q;
        address_d   = address_q;
        mb_read_d   = mb_read_q;
        writedata_d = writedata_q;

        case (state_q)
            S_IDLE: begin
                if (req_ok_c) begin
                    address_d  = bus.i_ma;
                    wr_flag_d  = bus.i_wr_rq;
                    addr_ack_d = 1'b1;
                    if (bus.i_rd_rq) begin
                        read_d  = 1'b1;
                        state_d = S_RD;
                    end else begin
                        state_d = S_WWAIT;
                    end
                end
            end
            S_RD: begin
                // Transfer always completes; only the response is gated by rq_cyc.
                if (!bus.i_waitrequest) begin
                    mb_read_d = bus.i_readdata;
                    read_d    = 1'b0;
                    rd_rs_d   = bus.i_rq_cyc;
                    state_d   = wr_flag_q ? S_WWAIT : S_DONE;
                end
            end
            S_WWAIT: begin
                if (!bus.i_rq_cyc) begin
                    state_d = S_IDLE;
                end else if (bus.i_wr_rs) begin
                    writedata_d = bus.i_mb_write;
                    write_d     = 1'b1;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (!bus.i_waitrequest) begin
                    write_d   = 1'b0;
                    wr_done_d = bus.i_rq_cyc;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                // Forces a low-high transition of rq_cyc between cycles.
                if (!bus.i_rq_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    assign bus.o_addr_ack  = addr_ack_q;
    assign bus.o_rd_rs     = rd_rs_q;
    assign bus.o_wr_done   = wr_done_q;
    assign bus.o_mb_read   = mb_read_q;
    assign bus.o_address   = address_q;
    assign bus.o_read      = read_q;
    assign bus.o_write     = write_q;
    assign bus.o_writedata = writedata_q;
endmodule

// File: doc/membus_avl_master.md
# membus_avl_master

Bridges one PDP-6 style memory-bus requester (processor or device: request cycle, read/write request, read/write restart) onto one Avalon-MM master port feeding one slave port of the two-port memory arbiter. It supports read, write and read-pause-write (RPW) cycles. It reports nonexistent memory by withholding address acknowledge. 36-bit words, 18-bit word addresses.

## Interface
- MEM_WORDS, 16384: words of memory present. Addresses >= MEM_WORDS are nonexistent and never acknowledged.
- i_clk  in  1  clock; all state changes on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_rq_cyc  in  1  requester holds high for the whole memory cycle
- i_rd_rq  in  1  read requested (qualified by i_rq_cyc)
- i_wr_rq  in  1  write requested. Both rd and wr high means RPW.
- i_ma  in  18  word address, stable while i_rq_cyc high
- i_wr_rs  in  1  write restart: i_mb_write valid, perform the write
- i_mb_write  in  36  write data
- o_addr_ack  out  1  one-cycle pulse: cycle accepted
- o_rd_rs  out  1  one-cycle pulse: o_mb_read valid
- o_mb_read  out  36  read data, held until next read completes
- o_wr_done  out  1  one-cycle pulse: write accepted by memory
- o_address  out  18  Avalon address
- o_read  out  1  Avalon read
- o_write  out  1  Avalon write
- o_writedata  out  36  Avalon write data
- i_readdata  in  36  Avalon read data, valid when o_read & ~i_waitrequest
- i_waitrequest  in  1  Avalon stall

## Operation
- **IDLE**: if i_rq_cyc & (i_rd_rq | i_wr_rq) & i_ma < MEM_WORDS:
  - Latch i_ma into o_address and latch the rd/wr flags.
  - Assert o_addr_ack for exactly one cycle.
  - Go to RD if rd, else WWAIT; o_read rises with o_addr_ack when rd.
  - Out-of-range address: stay IDLE with no outputs (NXM; the requester times out).
- **RD**: hold o_read and o_address until an edge with ~i_waitrequest.
  - On that edge, capture i_readdata into o_mb_read and drop o_read.
  - o_rd_rs pulses the next cycle if i_rq_cyc is still high.
  - Go to WWAIT if wr flag set (RPW), else DONE.
- **WWAIT**: on an edge with i_wr_rs high, capture i_mb_write into o_writedata, assert o_write, go to WR.
  - If i_rq_cyc is low, go to IDLE with no write (abandoned cycle).
- **WR**: hold o_write, o_writedata and o_address until an edge with ~i_waitrequest.
  - On that edge, drop o_write and pulse o_wr_done the next cycle.
  - Go to DONE.
- **DONE**: wait for i_rq_cyc low, then IDLE.
  - A request is never accepted in the same cycle i_rq_cyc falls, so every new cycle requires a low-high transition of i_rq_cyc.
- Avalon transfers in progress are never aborted by i_rq_cyc falling; the transfer completes and response pulses are suppressed.
- o_read and o_write are never both high.
- o_address is constant from acknowledge to the end of the cycle, including both phases of RPW.

## Timing
- Reset (asynchronous, immediate): all outputs 0, including o_mb_read and o_address; state IDLE.
  - Reset mid-transfer drops o_read/o_write immediately.
- Read latency with i_waitrequest low throughout: request sampled at edge 0; o_addr_ack and o_read high after edge 0; data captured at edge 1; o_rd_rs high after edge 1. Total 2 cycles.
- Write: o_write high one cycle after the edge sampling i_wr_rs. o_wr_done high one cycle after the accepting edge.
- Each i_waitrequest cycle adds exactly one cycle of latency. Outputs are stable during stall.
- i_wr_rs is ignored outside WWAIT. i_rd_rq, i_wr_rq and i_ma are ignored outside IDLE.
- Address check uses the full 18 bits. MEM_WORDS = 262144 disables NXM.

## Test plan
- **Read**: memory[0o4] = 0o123; rq_cyc+rd_rq at 0o4.
  - o_addr_ack exactly 1 cycle; o_read with o_address = 4.
  - o_rd_rs 2 cycles after request with o_mb_read = 0o123; then DONE until rq_cyc drops.
- **Write then read**: wr_rq at 0o5.
  - After ack, no o_write until wr_rs. wr_rs with data 0o1234 yields o_write with o_writedata = 0o1234, then o_wr_done.
  - A new read at 0o5 returns 0o1234.
- **RPW**: memory[0o6] = 0o444444.
  - o_rd_rs with 0o444444; no o_write until wr_rs.
  - wr_rs with data 0o444445; memory[0o6] = 0o444445 and o_address stays 6 throughout.
- **Stall**: hold i_waitrequest high for 10 cycles during a read (arbiter contention).
  - o_read/o_address stable for all 10 cycles; o_rd_rs exactly 1 cycle after release; one Avalon transaction only.
- **NXM**: MEM_WORDS = 16384, request at 0o40000 held 50 cycles.
  - No o_addr_ack and no Avalon activity.
  - After rq_cyc drops, a read at 0o4 proceeds normally.
- **Abandon and reset**:
  - RPW, drop rq_cyc in WWAIT: no o_write, memory unchanged, next request accepted.
  - Assert i_reset_n low mid-stall: all outputs 0 immediately; state IDLE after release.
